// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Operation encodings, FSM state type, default widths and small op decoders.
package muldiv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } md_state_e;

  // Bit 1 of the op code selects divide, bit 0 selects unsigned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Bundle between EX-stage control and the multiply/divide unit.
// master: pipeline side (issues ops, MTHI/MTLO); slave: muldiv_sequencer.
interface muldiv_if #(
  parameter int XLEN = 32
);

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            flush;
  logic            wr_hi;
  logic            wr_lo;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, flush, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, flush, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration shared by multiply and divide.
// Multiply (div_mode=0): acc = {partial_hi, product_lo}; adds operand to the
//   upper half when bit_in (current multiplier bit) is set, then shifts right.
// Divide (div_mode=1): acc = {remainder, quotient}; shifts bit_in (next
//   dividend bit, MSB first) into the remainder and restores on underflow.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              bit_in,
  input  logic              div_mode,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Single shift-add or restoring-subtract step.
  always_comb begin
    sum      = '0;
    shifted  = '0;
    diff     = '0;
    acc_next = acc;
    if (div_mode) begin
      shifted = {acc[2*XLEN-1:XLEN], bit_in};
      diff    = shifted - {1'b0, operand};
      // The remainder stays below the divisor, so the top diff bit is a
      // clean borrow flag.
      if (!diff[XLEN]) begin
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (bit_in ? {1'b0, operand} : '0);
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit with sequencing FSM and HI/LO registers.
// XLEN cycles per operation; busy is high exactly in RUN, done pulses in FIN.
// Optional MULDIV_EARLY_OUT_EN: zero multiply operand or zero divisor goes
// straight to FIN with the result written on the launch edge.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  md_state_e         state;
  md_state_e         state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN-1:0]   src_a;
  logic [XLEN-1:0]   src_b;
  logic              op_div;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;

  logic              launch;
  logic              finish;
  logic              early;
  logic              host_wr_ok;

  logic              new_div;
  logic              new_sa;
  logic              new_sb;
  logic [XLEN-1:0]   new_a;
  logic [XLEN-1:0]   new_b;

  logic              step_bit;
  logic [XLEN-1:0]   step_operand;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;

  // Decode the incoming operation and form magnitudes for signed ops.
  always_comb begin
    new_div = op_is_div(bus.op);
    new_sa  = op_is_signed(bus.op) & bus.rs_data[XLEN-1];
    new_sb  = op_is_signed(bus.op) & bus.rt_data[XLEN-1];
    new_a   = new_sa ? -bus.rs_data : bus.rs_data;
    new_b   = new_sb ? -bus.rt_data : bus.rt_data;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] early_hi;
  logic [XLEN-1:0] early_lo;

  // Zero operand results are known at launch: 0/0 for multiply, the
  // divide-by-zero pattern for divide.
  always_comb begin
    early    = new_div ? (bus.rt_data == '0)
                       : ((bus.rs_data == '0) || (bus.rt_data == '0));
    early_hi = new_div ? bus.rs_data : '0;
    early_lo = new_div ? '1 : '0;
  end
`else
  assign early = 1'b0;
`endif

  // Next-state and sequencing strobes; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          launch    = 1'b1;
          state_nxt = early ? FIN : RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(XLEN - 1)) begin
          finish    = 1'b1;
          state_nxt = FIN;
        end
      end
      FIN: begin
        if (bus.start) begin
          launch    = 1'b1;
          state_nxt = early ? FIN : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) begin
      state_nxt = IDLE;
      launch    = 1'b0;
      finish    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Multiply walks multiplier bits LSB first; divide feeds dividend bits MSB
  // first. ~cnt equals XLEN-1-cnt because 2^CNT_W == XLEN.
  always_comb begin
    step_bit     = op_div ? src_a[~cnt] : src_b[cnt];
    step_operand = op_div ? src_b : src_a;
  end

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .acc      (acc),
    .operand  (step_operand),
    .bit_in   (step_bit),
    .div_mode (op_div),
    .acc_next (acc_nxt)
  );

  // Sign fix on the final iteration's output. A zero divisor leaves the
  // dividend magnitude as remainder, so restoring the dividend's sign yields
  // the raw rs value; only the quotient needs overriding.
  always_comb begin
    prod   = (sign_a ^ sign_b) ? -acc_nxt : acc_nxt;
    quo    = (sign_a ^ sign_b) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem    = sign_a ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    if (src_b == '0) begin
      quo = '1;
    end
    res_hi = op_div ? rem : prod[2*XLEN-1:XLEN];
    res_lo = op_div ? quo : prod[XLEN-1:0];
  end

  assign host_wr_ok = (state == IDLE) || (state == FIN);

  // Operand latches, iteration datapath and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      src_a  <= '0;
      src_b  <= '0;
      op_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      // Host writes land first so a same-edge result commit overrides them.
      if (host_wr_ok) begin
        if (bus.wr_hi) hi_q <= bus.wdata;
        if (bus.wr_lo) lo_q <= bus.wdata;
      end
      if (launch) begin
        op_div <= new_div;
        sign_a <= new_sa;
        sign_b <= new_sb;
        src_a  <= new_a;
        src_b  <= new_b;
        acc    <= '0;
        cnt    <= '0;
`ifdef MULDIV_EARLY_OUT_EN
        if (early) begin
          hi_q <= early_hi;
          lo_q <= early_lo;
        end
`endif
      end else if (state == RUN) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        if (finish) begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == FIN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases with literal
// expectations plus randomized traffic against a cycle-count/arithmetic model.
// Honours MULDIV_EARLY_OUT_EN when the design is built with it.
module tb_muldiv_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   cmp_en;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(
    .XLEN  (32),
    .CNT_W (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic logic [63:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, q64, r64, res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    res = '0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      default: begin
        if (b == 32'h0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          if (op == 2'b10) begin
            sq  = sa / sb;
            sr  = sa % sb;
            q64 = sq;
            r64 = sr;
          end else begin
            q64 = ua / ub;
            r64 = ua % ub;
          end
          res = {r64[31:0], q64[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  function automatic bit early_case(input logic [1:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    return op[1] ? (b == 32'h0) : ((a == 32'h0) || (b == 32'h0));
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;
  bit          m_done;

  always @(posedge clk) begin
    logic [63:0] r;
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (bus.wr_hi) m_hi = bus.wdata;
        if (bus.wr_lo) m_lo = bus.wdata;
      end
      if (bus.flush) begin
        m_left = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (bus.start) begin
        r = ref_result(bus.op, bus.rs_data, bus.rt_data);
        if (early_case(bus.op, bus.rs_data, bus.rt_data)) begin
          m_hi = r[63:32]; m_lo = r[31:0]; m_done = 1'b1;
        end else begin
          p_hi = r[63:32]; p_lo = r[31:0]; m_left = 32;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(bus.busy), 32'(m_left > 0));
      check("done", 32'(bus.done), 32'(m_done));
      check("hi",   bus.hi, m_hi);
      check("lo",   bus.lo, m_lo);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.flush = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    bus.op = 2'b00; bus.rs_data = '0; bus.rt_data = '0; bus.wdata = '0;
  endtask

  task automatic wait_result(input string name, input int n0, input int exp_lat,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    n = n0;
    while (!bus.done && n < 40) begin
      cyc();
      n++;
    end
    check({name, "_lat"}, 32'(n), 32'(exp_lat));
    check({name, "_hi"}, bus.hi, exp_hi);
    check({name, "_lo"}, bus.lo, exp_lo);
  endtask

  task automatic do_op(input string name, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int exp_lat;
    exp_lat = early_case(op, a, b) ? 1 : 33;
    bus.op = op; bus.rs_data = a; bus.rt_data = b; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check({name, "_busy"}, 32'(bus.busy), 32'(exp_lat == 33));
    wait_result(name, 1, exp_lat, exp_hi, exp_lo);
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    checks = 0; errors = 0; cmp_en = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    cmp_en = 1'b1;
    cyc();
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    rst_n = 1'b1;
    cyc();

    do_op("mult_neg",  2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    do_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    do_op("div_zero_s", 2'b10, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
    do_op("mult_zero", 2'b00, 32'h1234_5678, 32'd0, 32'h0, 32'h0);
    cyc();

    // Preload HI, then abort a divide partway through.
    bus.wr_hi = 1'b1; bus.wdata = 32'h0000_AAAA;
    cyc();
    bus.wr_hi = 1'b0;
    check("mthi", bus.hi, 32'h0000_AAAA);
    bus.op = 2'b10; bus.rs_data = 32'd100; bus.rt_data = 32'd7; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (9) cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'h0);
    check("flush_done", 32'(bus.done), 32'h0);
    check("flush_hi", bus.hi, 32'h0000_AAAA);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("relaunch_busy", 32'(bus.busy), 32'h1);
    wait_result("div_100_7", 1, 33, 32'd2, 32'd14);

    // MTLO during RUN is dropped; launched straight from FIN.
    bus.op = 2'b01; bus.rs_data = 32'd5; bus.rt_data = 32'd6; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'h1);
    repeat (5) cyc();
    bus.wr_lo = 1'b1; bus.wdata = 32'h1234;
    cyc();
    bus.wr_lo = 1'b0;
    check("run_mtlo", bus.lo, 32'd14);
    wait_result("multu_5_6", 7, 33, 32'h0, 32'd30);

    // Flush together with start while in FIN: nothing launched, result kept.
    bus.flush = 1'b1; bus.start = 1'b1; bus.op = 2'b00;
    bus.rs_data = 32'd3; bus.rt_data = 32'd3;
    cyc();
    bus.flush = 1'b0; bus.start = 1'b0;
    check("fin_flush_busy", 32'(bus.busy), 32'h0);
    check("fin_flush_lo", bus.lo, 32'd30);

    // MTHI in the launch cycle lands, then the result overwrites it.
    bus.wr_hi = 1'b1; bus.wdata = 32'h5555; bus.start = 1'b1;
    bus.op = 2'b01; bus.rs_data = 32'd2; bus.rt_data = 32'd3;
    cyc();
    bus.wr_hi = 1'b0; bus.start = 1'b0;
    check("launch_mthi", bus.hi, 32'h5555);
    wait_result("multu_2_3", 1, 33, 32'h0, 32'd6);

    // Reset in the middle of an operation.
    bus.op = 2'b00; bus.rs_data = 32'd9; bus.rt_data = 32'd9; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (5) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_lo", bus.lo, 32'h0);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      bus.start   = ($urandom_range(0, 2) == 0);
      bus.op      = 2'($urandom_range(0, 3));
      bus.rs_data = rnd_data();
      bus.rt_data = rnd_data();
      bus.flush   = ($urandom_range(0, 39) == 0);
      bus.wr_hi   = ($urandom_range(0, 7) == 0);
      bus.wr_lo   = ($urandom_range(0, 7) == 0);
      bus.wdata   = $urandom();
      cyc();
    end
    idle_inputs();
    repeat (40) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
